me_wb_stage: RTL and testbench

Memory stage of the 5-stage MIPS pipeline: consumes the EX/ME register outputs, performs `lw`/`sw` against a word-addressed data memory with configurable access latency, and registers results into the ME/WB pipeline register. It drives `ResultW`, `WriteRegW` and `RegWriteW`, which feed register-file writeback and the EX-stage WB→EX forwarding path. While a multi-cycle access is in flight it raises `StallM`, so upstream stages hold.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/dmem_array.sv | 24 ++
 rtl/me_wb_stage.sv | 106 ++++++++++
 tb/tb_me_wb_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline memory stage.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  // Memory-stage state, derived from the access counter rather than stored.
  typedef enum logic [1:0] {
    MS_IDLE     = 2'd0,
    MS_WAIT     = 2'd1,
    MS_COMPLETE = 2'd2
  } ms_state_t;

  // ME/WB pipeline register contents.
  typedef struct packed {
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [WORD_W-1:0]     ALUOut;
    logic [WORD_W-1:0]     ReadData;
    logic [REG_ADDR_W-1:0] WriteReg;
  } mewb_t;

  // COMPLETE is checked first so that a zero-latency configuration sees
  // every access as already complete while the counter sits at zero.
  function automatic ms_state_t ms_decode(input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] lat);
    ms_state_t st;
    if (cnt == lat)
      st = MS_COMPLETE;
    else if (cnt == '0)
      st = MS_IDLE;
    else
      st = MS_WAIT;
    return st;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 512
) (
  input  logic                         Clock,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]            wdata,
  output logic [WORD_W-1:0]            rdata
);

  logic [WORD_W-1:0] mem [MEM_WORDS];

  // Store the word on the enabled edge; contents survive reset.
  always_ff @(posedge Clock) begin
    if (we)
      mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/me_wb_stage.sv
// MIPS memory stage: lw/sw against dmem_array with a configurable access
// latency, stall generation and the ME/WB pipeline register.
//
// state       | meaning
// ------------+----------------------------------------------------------
// MS_IDLE     | cnt == 0, no access in flight (or first stall cycle)
// MS_WAIT     | 0 < cnt < MEM_LATENCY, access in flight, StallM high
// MS_COMPLETE | cnt == MEM_LATENCY, access finishes on the next edge
module me_wb_stage
  import mips_pkg::*;
#(
  parameter int MEM_WORDS   = 512,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [WORD_W-1:0]     ALUResultM,
  input  logic [WORD_W-1:0]     WriteDataM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [WORD_W-1:0]     ResultW
);

  localparam int               IDX_W = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] LAT   = CNT_W'(MEM_LATENCY);

  logic [CNT_W-1:0]  cnt;
  ms_state_t         ms_state;
  logic              mem_op;
  logic              access;
  logic              complete;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [WORD_W-1:0] mem_rdata;
  mewb_t             mewb;
  mewb_t             mewb_next;

  // Misaligned accesses are suppressed entirely and complete in one cycle.
  assign mem_op    = MemtoRegM | MemWriteM;
  assign MisalignM = mem_op & (ALUResultM[1:0] != 2'b00);
  assign access    = mem_op & ~MisalignM;

  assign ms_state = ms_decode(cnt, LAT);

  // ResetN gating keeps upstream free to move while the stage is in reset.
  assign StallM   = ResetN & access & (ms_state != MS_COMPLETE);
  assign complete = access & ~StallM;

  // A store held across reset must not land in memory.
  assign mem_we  = ResetN & complete & MemWriteM;
  // Low index bits only, so out-of-range addresses wrap.
  assign mem_idx = ALUResultM[IDX_W+1:2];

  dmem_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_dmem (
    .Clock (Clock),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (WriteDataM),
    .rdata (mem_rdata)
  );

  // Access counter: counts stall edges, returns to zero on completion or
  // whenever no access is presented.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)
      cnt <= '0;
    else if (StallM)
      cnt <= cnt + CNT_W'(1);
    else
      cnt <= '0;
  end

  // Next ME/WB contents: a bubble while stalling, otherwise the finished
  // instruction. Stores win over loads, and misaligned loads never write back.
  always_comb begin
    mewb_next = '0;
    if (!StallM) begin
      mewb_next.RegWrite = RegWriteM & ~MemWriteM & ~(MisalignM & MemtoRegM);
      mewb_next.MemtoReg = MemtoRegM;
      mewb_next.ALUOut   = ALUResultM;
      mewb_next.ReadData = (complete & MemtoRegM & ~MemWriteM) ? mem_rdata : '0;
      mewb_next.WriteReg = WriteRegM;
    end
  end

  // ME/WB pipeline register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)
      mewb <= '0;
    else
      mewb <= mewb_next;
  end

  assign RegWriteW = mewb.RegWrite;
  assign WriteRegW = mewb.WriteReg;
  assign ResultW   = mewb.MemtoReg ? mewb.ReadData : mewb.ALUOut;

endmodule

// File: tb/tb_me_wb_stage.sv
// Directed scoreboard bench for me_wb_stage (latency-2 and latency-0 instances).
module tb_me_wb_stage;

  logic Clock = 1'b0;
  logic ResetN = 1'b0;

  always #5 Clock = ~Clock;

  // Instance A: MEM_LATENCY=2
  logic        a_rw, a_m2r, a_mw;
  logic [31:0] a_alu, a_wd;
  logic [4:0]  a_wr;
  logic        a_stall, a_mis, a_rww;
  logic [4:0]  a_wrw;
  logic [31:0] a_res;

  // Instance B: MEM_LATENCY=0
  logic        b_rw, b_m2r, b_mw;
  logic [31:0] b_alu, b_wd;
  logic [4:0]  b_wr;
  logic        b_stall, b_mis, b_rww;
  logic [4:0]  b_wrw;
  logic [31:0] b_res;

  me_wb_stage #(.MEM_WORDS(512), .MEM_LATENCY(2)) u_lat2 (
    .Clock(Clock), .ResetN(ResetN),
    .RegWriteM(a_rw), .MemtoRegM(a_m2r), .MemWriteM(a_mw),
    .ALUResultM(a_alu), .WriteDataM(a_wd), .WriteRegM(a_wr),
    .StallM(a_stall), .MisalignM(a_mis),
    .RegWriteW(a_rww), .WriteRegW(a_wrw), .ResultW(a_res)
  );

  me_wb_stage #(.MEM_WORDS(512), .MEM_LATENCY(0)) u_lat0 (
    .Clock(Clock), .ResetN(ResetN),
    .RegWriteM(b_rw), .MemtoRegM(b_m2r), .MemWriteM(b_mw),
    .ALUResultM(b_alu), .WriteDataM(b_wd), .WriteRegM(b_wr),
    .StallM(b_stall), .MisalignM(b_mis),
    .RegWriteW(b_rww), .WriteRegW(b_wrw), .ResultW(b_res)
  );

  typedef struct {
    bit          rw;
    logic [4:0]  wr;
    logic [31:0] res;
    bit          known;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_not(input string tag, input logic [31:0] obs, input logic [31:0] bad);
    n_total++;
    assert (obs !== bad) n_pass++;
    else $error("FAIL %s: observed %h expected anything but %h", tag, obs, bad);
  endtask

  // Present one instruction to instance d (0 = latency 2, 1 = latency 0),
  // check stall/bubble behaviour each edge, then check the ME/WB result.
  task automatic issue(input int d, input bit rw, input bit m2r, input bit mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input string tag);
    bit   mis, acc;
    int   lat, key;
    exp_t e;
    @(negedge Clock);
    if (d == 0) begin
      a_rw = rw; a_m2r = m2r; a_mw = mw; a_alu = alu; a_wd = wd; a_wr = wr;
    end else begin
      b_rw = rw; b_m2r = m2r; b_mw = mw; b_alu = alu; b_wd = wd; b_wr = wr;
    end
    mis = (m2r || mw) && (alu[1:0] != 2'b00);
    acc = (m2r || mw) && !mis;
    lat = acc ? ((d == 0) ? 2 : 0) : 0;
    key = d * 1024 + int'((alu >> 2) & 32'h1ff);
    e.wr    = wr;
    e.rw    = rw && !mw && !(mis && m2r);
    e.known = 1'b1;
    e.res   = 32'h0;
    if (!m2r)
      e.res = alu;
    else if (acc && !mw) begin
      if (model.exists(key)) e.res = model[key];
      else e.known = 1'b0;
    end
    sb.push_back(e);
    #1;
    chk({tag, "/misalign"}, (d == 0) ? a_mis : b_mis, mis);
    for (int k = 0; k < lat; k++) begin
      chk({tag, "/stall_hi"}, (d == 0) ? a_stall : b_stall, 1'b1);
      @(posedge Clock); #1;
      chk({tag, "/bubble_rw"}, (d == 0) ? a_rww : b_rww, 1'b0);
      chk({tag, "/bubble_wr"}, (d == 0) ? a_wrw : b_wrw, 5'd0);
      @(negedge Clock);
    end
    chk({tag, "/stall_lo"}, (d == 0) ? a_stall : b_stall, 1'b0);
    if (acc && mw) model[key] = wd;
    @(posedge Clock); #1;
    e = sb.pop_front();
    chk({tag, "/RegWriteW"}, (d == 0) ? a_rww : b_rww, e.rw);
    chk({tag, "/WriteRegW"}, (d == 0) ? a_wrw : b_wrw, e.wr);
    if (e.known)
      chk({tag, "/ResultW"}, (d == 0) ? a_res : b_res, e.res);
    else
      chk_not({tag, "/ResultW_stale"}, (d == 0) ? a_res : b_res, 32'hDEADBEEF);
  endtask

  initial begin
    a_rw = 0; a_m2r = 0; a_mw = 0; a_alu = 0; a_wd = 0; a_wr = 0;
    b_rw = 0; b_m2r = 0; b_mw = 0; b_alu = 0; b_wd = 0; b_wr = 0;
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst/a_stall", a_stall, 1'b0);
    chk("rst/a_rww",   a_rww,   1'b0);
    chk("rst/a_wrw",   a_wrw,   5'd0);
    chk("rst/a_res",   a_res,   32'h0);
    chk("rst/b_stall", b_stall, 1'b0);
    chk("rst/b_rww",   b_rww,   1'b0);
    chk("rst/b_wrw",   b_wrw,   5'd0);
    chk("rst/b_res",   b_res,   32'h0);
    @(negedge Clock);
    ResetN = 1'b1;

    issue(0, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 5'd3, "alu_pass");

    // Reset during the first stall cycle of a store.
    @(negedge Clock);
    a_rw = 0; a_m2r = 0; a_mw = 1; a_alu = 32'h10; a_wd = 32'hDEADBEEF; a_wr = 0;
    #1;
    chk("rst_mid/stall_before", a_stall, 1'b1);
    ResetN = 1'b0;
    #1;
    chk("rst_mid/stall", a_stall, 1'b0);
    chk("rst_mid/rww",   a_rww,   1'b0);
    chk("rst_mid/wrw",   a_wrw,   5'd0);
    chk("rst_mid/res",   a_res,   32'h0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    a_mw = 0; a_alu = 0; a_wd = 0;
    ResetN = 1'b1;
    issue(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd9, "rst_load");

    issue(0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678, 5'd0, "st40");
    issue(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd8, "ld40");
    issue(0, 1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd5, "ld_misalign");
    issue(0, 1'b0, 1'b0, 1'b1, 32'h41, 32'hFFFFFFFF, 5'd0, "st_misalign");
    issue(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd10, "ld40_again");
    issue(0, 1'b1, 1'b0, 1'b0, 32'hCAFEBABC, 32'h0, 5'd31, "alu_pass2");
    issue(0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0BADF00D, 5'd0, "st44");
    issue(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd12, "ld44");

    issue(1, 1'b0, 1'b0, 1'b1, 32'h800, 32'hA5A5A5A5, 5'd0, "l0_st_wrap");
    issue(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd2, "l0_ld_wrap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
